// File: rtl/internal_node_sender.sv
// ============================================================================
// Module      : internal_node_sender
// Description : Transmitter side of the internal-node load interface. Streams
//               host words into the KD-tree internal-node register array in
//               node-index order. Each session delivers exactly NUM_NODES
//               words. Words enter over a valid/ready handshake and pass
//               through a small FIFO. A one-cycle done pulse ends the session.
// Ports       : clk, rst           - clock, async active-high reset
//               start              - begin a session (honoured in IDLE only)
//               in_valid/in_data   - host word offer
//               in_ready           - sender accepts the host word this cycle
//               fsm_enable         - tree-load phase active (tree write gate)
//               sender_enable/data - word toward the currently addressed node
//               busy, done         - session status / end-of-session pulse
//               node_count         - words delivered in current/last session
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module internal_node_sender #(
    parameter int INTERNAL_WIDTH = 22,
    parameter int NUM_NODES      = 127,
    parameter int COUNT_WIDTH    = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [INTERNAL_WIDTH-1:0] in_data,
    output logic                      in_ready,
    input  logic                      fsm_enable,
    output logic                      sender_enable,
    output logic [INTERNAL_WIDTH-1:0] sender_data,
    output logic                      busy,
    output logic                      done,
    output logic [COUNT_WIDTH-1:0]    node_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(NUM_NODES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [PTR_W:0]         PTR_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]            rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0]    acc_cnt_q, acc_cnt_d;
    logic [COUNT_WIDTH-1:0]    node_cnt_q, node_cnt_d;
    logic [INTERNAL_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic in_send;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign in_send    = (state_q == ST_SEND);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // in_ready ignores a same-cycle pop: a full FIFO never accepts.
    assign in_ready      = in_send && !fifo_full && (acc_cnt_q < CNT_LAST);
    // The tree has no backpressure, so every enabled cycle is a transfer.
    assign sender_enable = in_send && !fifo_empty && fsm_enable;
    assign sender_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    assign push = in_valid && in_ready;
    assign pop  = sender_enable;

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign node_count = node_cnt_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        acc_cnt_d  = acc_cnt_q;
        node_cnt_d = node_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    acc_cnt_d  = '0;
                    node_cnt_d = '0;
                end
            end
            ST_SEND: begin
                // acc_cnt is bounded by in_ready; node_cnt by pops of
                // accepted words, so neither can pass NUM_NODES.
                if (push) begin
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                end
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    node_cnt_d = node_cnt_q + CNT_ONE;
                    if (node_cnt_q == CNT_LAST - CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            acc_cnt_q  <= '0;
            node_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            acc_cnt_q  <= acc_cnt_d;
            node_cnt_q <= node_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_internal_node_sender.sv
// ============================================================================
// Module      : tb_internal_node_sender
// Description : Directed self-checking bench for internal_node_sender. Host
//               words equal their node index, so the expected sender_data is
//               the number of transfers already made.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_internal_node_sender;

    localparam int W  = 22;
    localparam int N  = 127;
    localparam int CW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          fsm_enable;
    logic          sender_enable;
    logic [W-1:0]  sender_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] node_count;

    int checks   = 0;
    int failures = 0;

    internal_node_sender #(
        .INTERNAL_WIDTH(W),
        .NUM_NODES     (N),
        .COUNT_WIDTH   (CW),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .fsm_enable   (fsm_enable),
        .sender_enable(sender_enable),
        .sender_data  (sender_data),
        .busy         (busy),
        .done         (done),
        .node_count   (node_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},      32'(in_ready),      32'd0);
        chk({tag, "_sender_enable"}, 32'(sender_enable), 32'd0);
        chk({tag, "_sender_data"},   32'(sender_data),   32'd0);
        chk({tag, "_busy"},          32'(busy),          32'd0);
        chk({tag, "_done"},          32'(done),          32'd0);
        chk({tag, "_node_count"},    32'(node_count),    32'd0);
    endtask

    // vmode 0: in_valid every cycle, 1: every 3rd cycle.
    // fmode 0: fsm_enable held high, 1: toggled every 4 cycles.
    // abort_at > 0: assert rst once that many transfers have happened.
    // poke: pulse start during SEND and DONE (must be ignored).
    task automatic run_session(input int vmode, input int fmode, input int nwords,
                               input int abort_at, input bit poke);
        int occ = 0, acc = 0, xfer = 0, hidx = 0, obs_hs = 0, obs_xf = 0;
        bit fin = 1'b0, aborted = 1'b0, push, pop;

        start = 1'b1; in_valid = 1'b0; fsm_enable = 1'b0; in_data = '0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy",       32'(busy),       32'd1);
        chk("start_node_count", 32'(node_count), 32'd0);

        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            in_valid   = (hidx < nwords) && (vmode == 0 || cyc % 3 == 0);
            in_data    = W'(hidx);
            fsm_enable = (fmode == 0) || ((cyc / 4) % 2 == 0);
            start      = poke && (cyc == 20);
            #1;
            chk("in_ready",      32'(in_ready),      32'(occ < D && acc < N));
            chk("sender_enable", 32'(sender_enable), 32'(occ > 0 && fsm_enable));
            chk("sender_data",   32'(sender_data),   (occ > 0) ? 32'(xfer) : 32'd0);
            chk("node_count",    32'(node_count),    32'(xfer));
            chk("done_low",      32'(done),          32'd0);
            chk("busy_high",     32'(busy),          32'd1);
            if (in_valid && in_ready) obs_hs++;
            if (sender_enable)        obs_xf++;
            push = in_valid && (occ < D) && (acc < N);
            pop  = (occ > 0) && fsm_enable;
            if (push) begin acc++; hidx++; end
            if (pop)  xfer++;
            occ = occ + int'(push) - int'(pop);
            @(posedge clk); #1;
            start = 1'b0;
            if (abort_at > 0 && xfer == abort_at) begin
                in_valid = 1'b0; fsm_enable = 1'b0;
                chk("pre_abort_node_count", 32'(node_count), 32'(abort_at));
                #1 rst = 1'b1;
                #1;
                chk_all_zero("abort_async");
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", 32'(done), 32'd0);
                end
                rst = 1'b0;
                aborted = 1'b1;
                fin = 1'b1;
            end else if (xfer == N) begin
                chk("done_pulse",      32'(done),          32'd1);
                chk("done_busy",       32'(busy),          32'd1);
                chk("done_node_count", 32'(node_count),    32'(N));
                chk("done_sender_en",  32'(sender_enable), 32'd0);
                chk("done_in_ready",   32'(in_ready),      32'd0);
                start = poke;
                @(posedge clk); #1;
                start = 1'b0;
                chk("idle_done",       32'(done),       32'd0);
                chk("idle_busy",       32'(busy),       32'd0);
                chk("idle_node_count", 32'(node_count), 32'(N));
                chk("idle_data",       32'(sender_data), 32'd0);
                @(posedge clk); #1;
                chk("idle_hold_busy",  32'(busy),       32'd0);
                chk("idle_hold_count", 32'(node_count), 32'(N));
                fin = 1'b1;
            end
        end
        chk("session_finished", 32'(fin), 32'd1);
        if (!aborted) begin
            chk("handshakes", 32'(obs_hs), 32'(N));
            chk("transfers",  32'(obs_xf), 32'(N));
        end
        in_valid = 1'b0; fsm_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; fsm_enable = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_session(0, 0, 127, 0,  1'b0);  // streaming load
        run_session(0, 1, 127, 0,  1'b0);  // fsm_enable toggling
        run_session(1, 0, 127, 0,  1'b0);  // sparse host valid
        run_session(0, 0, 130, 0,  1'b1);  // over-offer, start pokes
        run_session(0, 0, 127, 50, 1'b0);  // reset mid-session
        run_session(0, 0, 127, 0,  1'b0);  // fresh session after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
